// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M/RV64M multiply/divide for the EX stage.
// Radix-2 shift-add multiply and restoring divide, one bit per clock, with a
// start/busy/done handshake. Divide-by-zero and signed overflow finish one
// edge after start.
// Optional build macro MULDIV_EARLY_OUT_EN: also finishes a multiply with a
// zero operand, and a divide with |op_a| < |op_b|, one edge after start.
module muldiv_unit #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int unsigned CNT_W = $clog2(XLEN) + 1;
  localparam int unsigned PW    = 2 * XLEN;
  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MUL,
    ST_DIV
  } state_t;

  // Registered state
  state_t           state_q, state_d;
  logic             busy_d, done_d;
  logic [XLEN-1:0]  result_d;
  logic [PW-1:0]    acc_q, acc_d;     // mul: {partial product, multiplier}; div: {remainder, quotient}
  logic [XLEN-1:0]  divs_q, divs_d;   // multiplicand / divisor magnitude
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       f3_q, f3_d;       // funct3[1:0] of the operation in flight
  logic             negq_q, negq_d;   // product / quotient sign
  logic             negr_q, negr_d;   // remainder sign
  logic             fast_q, fast_d;   // one-edge result parked in acc_q[XLEN-1:0]

  // Capture-edge helpers
  logic             a_signed_c, b_signed_c;
  logic             a_neg_c, b_neg_c;
  logic [XLEN-1:0]  a_mag_c, b_mag_c;
  logic             ovf_c, eo_mul_c, eo_div_c;

  // Iteration datapath
  logic [XLEN:0]    mul_sum_c;
  logic [PW-1:0]    mul_nxt_c, mul_fix_c;
  logic [XLEN-1:0]  mul_res_c;
  logic [XLEN:0]    rem_sh_c;
  logic             div_ge_c;
  logic [XLEN-1:0]  rem_dif_c, rem_nxt_c, quo_nxt_c;
  logic [XLEN-1:0]  quo_fix_c, rem_fix_c, div_res_c;
  logic [PW-1:0]    div_nxt_c;

  // Operand signedness, magnitudes and special-case detection at the start edge
  always_comb begin
    a_signed_c = funct3[2] ? ~funct3[0] : (funct3[1:0] != 2'b11);
    b_signed_c = funct3[2] ? ~funct3[0] : ~funct3[1];
    a_neg_c    = a_signed_c & op_a[XLEN-1];
    b_neg_c    = b_signed_c & op_b[XLEN-1];
    a_mag_c    = a_neg_c ? (~op_a + XLEN'(1)) : op_a;
    b_mag_c    = b_neg_c ? (~op_b + XLEN'(1)) : op_b;
    ovf_c      = ~funct3[0] && (op_a == INT_MIN) && (op_b == {XLEN{1'b1}});
`ifdef MULDIV_EARLY_OUT_EN
    eo_mul_c   = (op_a == '0) || (op_b == '0);
    eo_div_c   = a_mag_c < b_mag_c;
`else
    eo_mul_c   = 1'b0;
    eo_div_c   = 1'b0;
`endif
  end

  // One multiply step, one divide step, and the sign-corrected final results
  always_comb begin
    mul_sum_c = {1'b0, acc_q[PW-1:XLEN]} + (acc_q[0] ? {1'b0, divs_q} : '0);
    mul_nxt_c = {mul_sum_c, acc_q[XLEN-1:1]};
    mul_fix_c = negq_q ? (~mul_nxt_c + PW'(1)) : mul_nxt_c;
    mul_res_c = (f3_q == 2'b00) ? mul_fix_c[XLEN-1:0] : mul_fix_c[PW-1:XLEN];

    rem_sh_c  = acc_q[PW-1:XLEN-1];
    div_ge_c  = rem_sh_c >= {1'b0, divs_q};
    rem_dif_c = rem_sh_c[XLEN-1:0] - divs_q;
    rem_nxt_c = div_ge_c ? rem_dif_c : rem_sh_c[XLEN-1:0];
    quo_nxt_c = {acc_q[XLEN-2:0], div_ge_c};
    div_nxt_c = {rem_nxt_c, quo_nxt_c};
    quo_fix_c = negq_q ? (~quo_nxt_c + XLEN'(1)) : quo_nxt_c;
    rem_fix_c = negr_q ? (~rem_nxt_c + XLEN'(1)) : rem_nxt_c;
    div_res_c = f3_q[1] ? rem_fix_c : quo_fix_c;
  end

  // Next-state and next-output logic
  always_comb begin
    state_d  = state_q;
    busy_d   = busy;
    done_d   = 1'b0;
    result_d = result;
    acc_d    = acc_q;
    divs_d   = divs_q;
    cnt_d    = cnt_q;
    f3_d     = f3_q;
    negq_d   = negq_q;
    negr_d   = negr_q;
    fast_d   = 1'b0;

    if (flush) begin
      // Abort anything in flight; a coincident start is dropped
      state_d = ST_IDLE;
      busy_d  = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (fast_q) begin
            result_d = acc_q[XLEN-1:0];
            done_d   = 1'b1;
            busy_d   = 1'b0;
          end else if (start && !busy) begin
            f3_d   = funct3[1:0];
            divs_d = b_mag_c;
            negq_d = a_neg_c ^ b_neg_c;
            negr_d = a_neg_c;
            cnt_d  = CNT_W'(XLEN);
            busy_d = 1'b1;
            acc_d  = {{XLEN{1'b0}}, a_mag_c};
            if (!funct3[2]) begin
              if (eo_mul_c) begin
                fast_d = 1'b1;
                acc_d  = '0;
              end else begin
                state_d = ST_MUL;
              end
            end else if (op_b == '0) begin
              fast_d = 1'b1;
              acc_d  = {{XLEN{1'b0}}, (funct3[1] ? op_a : {XLEN{1'b1}})};
            end else if (ovf_c) begin
              fast_d = 1'b1;
              acc_d  = {{XLEN{1'b0}}, (funct3[1] ? {XLEN{1'b0}} : op_a)};
            end else if (eo_div_c) begin
              fast_d = 1'b1;
              acc_d  = {{XLEN{1'b0}}, (funct3[1] ? op_a : {XLEN{1'b0}})};
            end else begin
              state_d = ST_DIV;
            end
          end
        end
        ST_MUL: begin
          acc_d = mul_nxt_c;
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_d  = ST_IDLE;
            busy_d   = 1'b0;
            done_d   = 1'b1;
            result_d = mul_res_c;
          end
        end
        ST_DIV: begin
          acc_d = div_nxt_c;
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_d  = ST_IDLE;
            busy_d   = 1'b0;
            done_d   = 1'b1;
            result_d = div_res_c;
          end
        end
        default: begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end
      endcase
    end
  end

  // State, datapath and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      result  <= '0;
      acc_q   <= '0;
      divs_q  <= '0;
      cnt_q   <= '0;
      f3_q    <= '0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
      fast_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      busy    <= busy_d;
      done    <= done_d;
      result  <= result_d;
      acc_q   <= acc_d;
      divs_q  <= divs_d;
      cnt_q   <= cnt_d;
      f3_q    <= f3_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
      fast_q  <= fast_d;
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed vector table, randomized ops against an arithmetic
// reference model, and hand-written flush / back-to-back / reset sequences.
module tb_muldiv_unit;

  localparam int unsigned XLEN = 32;
  localparam int MAX_WAIT = 200;
`ifdef MULDIV_EARLY_OUT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif
  localparam int EO_LAT = EARLY ? 1 : 32;

  logic            clk;
  logic            rst_n;
  logic            start;
  logic [2:0]      funct3;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic            flush;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;

  int checks;
  int failures;

  typedef struct {
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[20];

  muldiv_unit #(.XLEN(XLEN)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .funct3 (funct3),
    .op_a   (op_a),
    .op_b   (op_b),
    .flush  (flush),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // RISC-V M-extension results from plain 64-bit arithmetic
  function automatic logic [31:0] ref_result(input logic [2:0] f, input logic [31:0] a,
                                             input logic [31:0] b);
    int          ia, ib;
    longint      sa, sb, ua, ub;
    logic [63:0] p;
    ia = a;
    ib = b;
    sa = ia;
    sb = ib;
    ua = {32'b0, a};
    ub = {32'b0, b};
    case (f)
      3'b000: begin p = sa * sb; return p[31:0]; end
      3'b001: begin p = sa * sb; return p[63:32]; end
      3'b010: begin p = sa * ub; return p[63:32]; end
      3'b011: begin p = ua * ub; return p[63:32]; end
      3'b100: begin
        if (b == 0) return 32'hFFFFFFFF;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return a;
        p = sa / sb;
        return p[31:0];
      end
      3'b101: begin
        if (b == 0) return 32'hFFFFFFFF;
        p = ua / ub;
        return p[31:0];
      end
      3'b110: begin
        if (b == 0) return a;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h0;
        p = sa % sb;
        return p[31:0];
      end
      default: begin
        if (b == 0) return a;
        p = ua % ub;
        return p[31:0];
      end
    endcase
  endfunction

  // Edges from start to done
  function automatic int exp_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] ma, mb;
    bit          sgn;
    if (!f[2]) return (EARLY && (a == 0 || b == 0)) ? 1 : 32;
    if (b == 0) return 1;
    sgn = !f[0];
    if (sgn && a == 32'h80000000 && b == 32'hFFFFFFFF) return 1;
    ma = (sgn && a[31]) ? -a : a;
    mb = (sgn && b[31]) ? -b : b;
    if (EARLY && ma < mb) return 1;
    return 32;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'hFFFFFFFF;
      2: return 32'h80000000;
      3: return 32'($urandom_range(0, 15));
      default: return 32'($urandom());
    endcase
  endfunction

  // Called 1 time unit after edge 0; returns in the done cycle
  task automatic wait_done(output int lat, output int bcnt);
    lat  = 0;
    bcnt = 0;
    while (done !== 1'b1 && lat < MAX_WAIT) begin
      if (busy === 1'b1) bcnt++;
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic do_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] r, output int lat, output int bcnt);
    @(negedge clk);
    start  = 1'b1;
    funct3 = f;
    op_a   = a;
    op_b   = b;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(lat, bcnt);
    r = result;
  endtask

  initial begin
    logic [31:0] r, prev;
    logic [2:0]  f;
    logic [31:0] a, b;
    int          lat, bcnt, lat2;
    bit          saw;

    checks   = 0;
    failures = 0;
    start    = 1'b0;
    funct3   = 3'b000;
    op_a     = '0;
    op_b     = '0;
    flush    = 1'b0;
    rst_n    = 1'b0;

    vecs = '{
      '{3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 32},
      '{3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 32},
      '{3'b011, 32'h80000000, 32'h80000000, 32'h40000000, 32},
      '{3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32},
      '{3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 32},
      '{3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32},
      '{3'b101, 32'd100,      32'd7,        32'd14,       32},
      '{3'b111, 32'd100,      32'd7,        32'd2,        32},
      '{3'b101, 32'd100,      32'd0,        32'hFFFFFFFF, 1},
      '{3'b111, 32'd100,      32'd0,        32'd100,      1},
      '{3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1},
      '{3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h0,        1},
      '{3'b000, 32'd3,        32'd4,        32'd12,       32},
      '{3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0,        32},
      '{3'b110, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 1},
      '{3'b000, 32'd0,        32'd5,        32'd0,        EO_LAT},
      '{3'b101, 32'd3,        32'd10,       32'd0,        EO_LAT},
      '{3'b111, 32'd3,        32'd10,       32'd3,        EO_LAT},
      '{3'b101, 32'h80000000, 32'hFFFFFFFF, 32'h0,        EO_LAT},
      '{3'b110, 32'd5,        32'hFFFFFFFD, 32'd2,        32}
    };

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("reset.busy", 32'(busy), 32'd0);
    check("reset.done", 32'(done), 32'd0);
    check("reset.result", result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed vector table
    for (int i = 0; i < 20; i++) begin
      do_op(vecs[i].f, vecs[i].a, vecs[i].b, r, lat, bcnt);
      check($sformatf("vec%0d.result", i), r, vecs[i].exp);
      check($sformatf("vec%0d.latency", i), 32'(lat), 32'(vecs[i].lat));
      check($sformatf("vec%0d.busy_cycles", i), 32'(bcnt), 32'(vecs[i].lat));
      check($sformatf("vec%0d.busy_in_done", i), 32'(busy), 32'd0);
      @(posedge clk);
      #1;
      check($sformatf("vec%0d.done_pulse", i), 32'(done), 32'd0);
    end

    // Randomized operations against the reference model
    for (int i = 0; i < 40; i++) begin
      f = 3'($urandom_range(0, 7));
      a = pick();
      b = pick();
      do_op(f, a, b, r, lat, bcnt);
      check($sformatf("rnd%0d.f%0d.a%08h.b%08h.result", i, f, a, b), r, ref_result(f, a, b));
      check($sformatf("rnd%0d.latency", i), 32'(lat), 32'(exp_lat(f, a, b)));
    end

    // Flush at edge 10 of a DIVU: no done, result unchanged
    prev = result;
    @(negedge clk);
    start  = 1'b1;
    funct3 = 3'b101;
    op_a   = 32'd1000;
    op_b   = 32'd3;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    check("flush.busy_before", 32'(busy), 32'd1);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    check("flush.busy_after", 32'(busy), 32'd0);
    check("flush.done_after", 32'(done), 32'd0);
    saw = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) saw = 1'b1;
    end
    check("flush.no_done", 32'(saw), 32'd0);
    check("flush.result_kept", result, prev);

    // Flush and start on the same edge: start dropped
    @(negedge clk);
    start  = 1'b1;
    flush  = 1'b1;
    funct3 = 3'b000;
    op_a   = 32'd9;
    op_b   = 32'd9;
    @(posedge clk);
    #1;
    start = 1'b0;
    flush = 1'b0;
    check("flush_start.busy", 32'(busy), 32'd0);
    saw = 1'b0;
    repeat (35) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) saw = 1'b1;
    end
    check("flush_start.no_done", 32'(saw), 32'd0);
    check("flush_start.result_kept", result, prev);

    do_op(3'b000, 32'd3, 32'd4, r, lat, bcnt);
    check("post_flush.mul", r, 32'd12);
    check("post_flush.latency", 32'(lat), 32'd32);

    // Start while busy is ignored, operands not re-captured
    @(negedge clk);
    start  = 1'b1;
    funct3 = 3'b000;
    op_a   = 32'd7;
    op_b   = 32'hFFFFFFFD;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    start  = 1'b1;
    funct3 = 3'b101;
    op_a   = 32'd50;
    op_b   = 32'd5;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(lat, bcnt);
    check("busy_start.result", result, 32'hFFFFFFEB);
    check("busy_start.latency", 32'(lat + 5), 32'd32);

    // Back-to-back: start sampled in the done cycle
    do_op(3'b000, 32'd6, 32'd7, r, lat, bcnt);
    check("b2b.first", r, 32'd42);
    check("b2b.done_cycle", 32'(done), 32'd1);
    start  = 1'b1;
    funct3 = 3'b101;
    op_a   = 32'd100;
    op_b   = 32'd7;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("b2b.accepted", 32'(busy), 32'd1);
    wait_done(lat2, bcnt);
    check("b2b.second", result, 32'd14);
    check("b2b.latency", 32'(lat2), 32'd32);

    // Asynchronous reset in the middle of a DIV
    @(negedge clk);
    start  = 1'b1;
    funct3 = 3'b100;
    op_a   = 32'hFFFFFFF9;
    op_b   = 32'd2;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("midreset.busy", 32'(busy), 32'd0);
    check("midreset.done", 32'(done), 32'd0);
    check("midreset.result", result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    saw = 1'b0;
    repeat (35) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) saw = 1'b1;
    end
    check("midreset.no_done", 32'(saw), 32'd0);
    do_op(3'b000, 32'd5, 32'd5, r, lat, bcnt);
    check("midreset.mul", r, 32'd25);
    check("midreset.latency", 32'(lat), 32'd32);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative RV32M/RV64M multiply/divide unit for the pipelined core's EX stage.
- Executes MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM and REMU with a start/busy/done handshake.
- While busy is high, the hazard unit stalls IF/ID/EX.
- Radix-2 shift-add multiply and restoring divide; one bit per cycle.

Parameters:
XLEN, 32, operand and result width in bits; legal values 32 and 64.
CNT_W, $clog2(XLEN)+1, iteration counter width; derived, never overridden.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  request; sampled only when busy=0
funct3  input  3  RISC-V M-extension funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
op_a  input  XLEN  rs1 value, captured at the start edge
op_b  input  XLEN  rs2 value, captured at the start edge
flush  input  1  abort the operation in flight (branch mispredict or trap)
busy  output  1  operation in progress; stall request
done  output  1  one-cycle pulse; result valid
result  output  XLEN  registered result, held until the next done

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE; busy=0, done=0, result=0; counter and internal registers are cleared.
- Clock convention: edge 0 is the edge that samples start=1 with busy=0.
- FSM states: IDLE, MUL, DIV.
- IDLE -> MUL when funct3[2]=0.
- IDLE -> DIV when funct3[2]=1 and no fast path applies.
- IDLE -> IDLE with a fast-path result registered at edge 1 otherwise.
- Operand capture at edge 0 (mul):
  - Operand signs are taken per funct3: MULH signed x signed, MULHSU signed x unsigned, MULHU unsigned x unsigned.
  - Magnitudes are latched; the result sign is recorded.
- Operand capture at edge 0 (div):
  - DIV and REM are signed; DIVU and REMU are unsigned.
  - Magnitudes are latched. Quotient sign = sign(a) XOR sign(b). Remainder sign = sign(a).
- Iteration: one step per edge, edges 1..XLEN. counter is loaded with XLEN and decrements to 0.
- Completion at edge XLEN:
  - result is registered already sign-corrected; done=1 for exactly the following cycle; busy=0 from that cycle.
  - MUL returns the low XLEN bits of the 2*XLEN product.
  - MULH, MULHSU and MULHU return the high XLEN bits.
- Fast paths (DIV family only) complete at edge 1: busy=1 for one cycle, then done=1.
  - op_b=0: DIV/DIVU give all ones; REM/REMU give op_a.
  - DIV/REM with op_a=-2^(XLEN-1) and op_b=-1: quotient = op_a, remainder = 0.
- Back-to-back: start may be sampled in the done cycle, since busy=0. The new operation's edge 0 is that edge.
- start while busy=1: ignored; op_a, op_b and funct3 are not re-captured.
- flush=1 on any edge while busy=1: return to IDLE; no done is produced; result keeps its previous value.
- Priority: flush wins over start on the same edge; that start is dropped.
- Reset mid-operation: immediate return to reset values; no done.
- All outputs are registered; there is no combinational path from any input to any output.

Optional Feature:
MULDIV_EARLY_OUT_EN
- Defined:
  - DIV family: when |op_a| < |op_b| (unsigned compare of the captured magnitudes), complete at edge 1 with quotient 0 and remainder op_a.
  - MUL family: when op_a=0 or op_b=0, complete at edge 1 with result 0.
- Not defined: these cases take the full XLEN iterations; the results are identical.

Test Plan:
- XLEN=32, MUL 7 x 0xFFFFFFFD (-3) -> result 0xFFFFFFEB; done exactly 32 edges after the start edge; busy high for 32 cycles.
- MULH 0x80000000 x 0x80000000 -> 0x40000000. MULHU on the same operands -> 0x40000000. MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF.
- DIV 0xFFFFFFF9 (-7) / 2 -> 0xFFFFFFFD. REM on the same operands -> 0xFFFFFFFF. DIVU 100/7 -> 14. REMU 100/7 -> 2.
- Divide-by-zero and overflow:
  - DIVU 100/0 -> 0xFFFFFFFF; REMU 100/0 -> 100; both with done after edge 1.
  - DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM on the same operands -> 0; both with done after edge 1.
- Flush and back-to-back:
  - Start DIVU; assert flush at edge 10 -> busy=0 after edge 10, no done pulse, result unchanged.
  - Start MUL 3x4 in the same cycle flush is low -> 12 after 32 edges.
  - Back-to-back start in the done cycle is accepted.
- Reset mid-op: assert rst_n=0 asynchronously at cycle 5 of a DIV -> busy, done and result are 0 immediately. After release, a new MUL 5x5 -> 25.
